// File: rtl/uart_link_ctrl_if.sv
// rtl/uart_link_ctrl_if.sv - signal bundle between the UART register block, TX/RX engines and the link controller
//
// Purpose: groups the configuration, engine status, flow-control pins and
// scheduler outputs of uart_link_ctrl into one interface.
// Modports:
//   slave  - the link controller (consumes config/status, drives grants and line control)
//   master - the surrounding register block / shift engines / pins
// Signals:
//   mode_i, master_i, flow_control_i   link configuration from the register block
//   tx_pending_i, tx_busy_i            TX FIFO non-empty, TX engine shifting
//   rx_busy_i, rx_almost_full_i        RX engine mid-frame, RX FIFO at watermark
//   cts_n_i                            asynchronous clear-to-send pin, active-low
//   tx_start_o                         one-cycle frame start grant
//   rx_en_o, line_dir_o, rts_n_o       receiver enable, driver enable, request-to-send
//   state_o                            half-duplex scheduler state
interface uart_link_ctrl_if;
  logic [1:0] mode_i;
  logic       master_i;
  logic       flow_control_i;
  logic       tx_pending_i;
  logic       tx_busy_i;
  logic       rx_busy_i;
  logic       rx_almost_full_i;
  logic       cts_n_i;
  logic       tx_start_o;
  logic       rx_en_o;
  logic       line_dir_o;
  logic       rts_n_o;
  logic [1:0] state_o;

  modport slave (
    input  mode_i, master_i, flow_control_i, tx_pending_i, tx_busy_i,
    input  rx_busy_i, rx_almost_full_i, cts_n_i,
    output tx_start_o, rx_en_o, line_dir_o, rts_n_o, state_o
  );

  modport master (
    output mode_i, master_i, flow_control_i, tx_pending_i, tx_busy_i,
    output rx_busy_i, rx_almost_full_i, cts_n_i,
    input  tx_start_o, rx_en_o, line_dir_o, rts_n_o, state_o
  );
endinterface

// File: rtl/uart_link_ctrl.sv
// rtl/uart_link_ctrl.sv - UART line scheduler for simplex, half-duplex and full-duplex links
//
// Purpose: grants frame starts to the TX engine, enables the receiver, drives
// the half-duplex driver-enable and applies RTS/CTS flow control.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - uart_link_ctrl_if.slave (config, engine status, pins, grants)
// All outputs are registered.
module uart_link_ctrl #(
  parameter int TURNAROUND_CYCLES = 16,
  parameter int RX_IDLE_CYCLES    = 160,
  parameter int CNT_W             = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_link_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TX   = 2'b01,
    S_TURN = 2'b10,
    S_RX   = 2'b11
  } state_t;

  localparam logic [1:0]       MODE_HALF = 2'b01;
  localparam logic [1:0]       MODE_FULL = 2'b10;
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND_CYCLES - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Active configuration
  logic [1:0]       r_mode;
  logic             r_master;
  logic             r_fc;
  // CTS synchroniser
  logic             r_cts_s1;
  logic             r_cts_s2;
  // Scheduler state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  // Registered outputs
  logic             r_tx_start;
  logic             r_rx_en;
  logic             r_line_dir;
  logic             r_rts_n;

  logic             w_cfg_load;
  logic [1:0]       w_mode_nxt;
  logic             w_master_nxt;
  logic             w_fc_nxt;
  logic             w_cur_half;
  logic             w_nxt_half;
  logic             w_nxt_full;
  logic             w_may_tx;
  logic             w_tx_allowed;
  logic             w_tx_start_nxt;
  logic             w_rx_en_nxt;
  logic             w_line_dir_nxt;
  logic             w_rts_n_nxt;

  // Config only changes between frames, so a mode switch never splits one.
  assign w_cfg_load   = ~bus.tx_busy_i & ~bus.rx_busy_i & ~r_tx_start;
  assign w_mode_nxt   = w_cfg_load ? bus.mode_i         : r_mode;
  assign w_master_nxt = w_cfg_load ? bus.master_i       : r_master;
  assign w_fc_nxt     = w_cfg_load ? bus.flow_control_i : r_fc;

  assign w_cur_half = (r_mode == MODE_HALF);
  assign w_nxt_half = (w_mode_nxt == MODE_HALF);
  assign w_nxt_full = (w_mode_nxt == MODE_FULL);

  // The ~r_tx_start term forces a gap cycle between grants while the engine
  // has not yet raised tx_busy_i. CTS only gates new starts.
  assign w_may_tx = bus.tx_pending_i & ~bus.tx_busy_i & ~r_tx_start &
                    (~w_fc_nxt | ~r_cts_s2);

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_tx_allowed   = 1'b0;
    w_rx_en_nxt    = 1'b0;
    w_line_dir_nxt = 1'b0;

    if (!w_nxt_half || !w_cur_half) begin
      // Leaving half-duplex, or just entering it: park in IDLE.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A start bit already on the line takes priority over a pending TX.
          if (bus.rx_busy_i) begin
            w_state_nxt = S_RX;
            w_cnt_nxt   = '0;
          end else if (w_may_tx) begin
            w_state_nxt = S_TX;
          end
        end
        S_TX: begin
          w_tx_allowed = 1'b1;
          if (!bus.tx_pending_i && !bus.tx_busy_i && !r_tx_start) begin
            w_state_nxt = S_TURN;
            w_cnt_nxt   = '0;
          end
        end
        S_TURN: begin
          if (r_cnt == TURN_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_RX: begin
          if (bus.rx_busy_i) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == RX_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    if (!w_nxt_half) begin
      w_tx_allowed = w_nxt_full | w_master_nxt;
    end

    // Line control follows the configuration/state being entered so the
    // registered outputs line up with state_o.
    if (w_nxt_half) begin
      case (w_state_nxt)
        S_IDLE:  begin w_rx_en_nxt = 1'b1; w_line_dir_nxt = 1'b0; end
        S_TX:    begin w_rx_en_nxt = 1'b0; w_line_dir_nxt = 1'b1; end
        S_TURN:  begin w_rx_en_nxt = 1'b0; w_line_dir_nxt = 1'b0; end
        default: begin w_rx_en_nxt = 1'b1; w_line_dir_nxt = 1'b0; end
      endcase
    end else if (w_nxt_full) begin
      w_rx_en_nxt    = 1'b1;
      w_line_dir_nxt = 1'b1;
    end else begin
      w_rx_en_nxt    = ~w_master_nxt;
      w_line_dir_nxt = w_master_nxt;
    end
  end

  assign w_tx_start_nxt = w_may_tx & w_tx_allowed;
  assign w_rts_n_nxt    = w_fc_nxt & (bus.rx_almost_full_i | ~w_rx_en_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= 2'b00;
      r_master   <= 1'b0;
      r_fc       <= 1'b0;
      r_cts_s1   <= 1'b1;
      r_cts_s2   <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_rx_en    <= 1'b0;
      r_line_dir <= 1'b0;
      r_rts_n    <= 1'b1;
    end else begin
      r_mode     <= w_mode_nxt;
      r_master   <= w_master_nxt;
      r_fc       <= w_fc_nxt;
      r_cts_s1   <= bus.cts_n_i;
      r_cts_s2   <= r_cts_s1;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_rx_en    <= w_rx_en_nxt;
      r_line_dir <= w_line_dir_nxt;
      r_rts_n    <= w_rts_n_nxt;
    end
  end

  assign bus.tx_start_o = r_tx_start;
  assign bus.rx_en_o    = r_rx_en;
  assign bus.line_dir_o = r_line_dir;
  assign bus.rts_n_o    = r_rts_n;
  assign bus.state_o    = r_state;

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
- Line-level scheduler between the UART register block and the TX/RX shift engines.
- Owns the link policy for simplex, half-duplex and full-duplex operation.
- Grants frame starts to the transmitter and enables or disables the receiver.
- Drives the half-duplex driver-enable and applies RTS/CTS hardware flow control.

Parameters:
TURNAROUND_CYCLES, 16, guard cycles with line released after a half-duplex TX burst
RX_IDLE_CYCLES, 160, idle cycles after last RX frame before half-duplex link released
CNT_W, 16, guard/idle counter width; must hold max(TURNAROUND_CYCLES, RX_IDLE_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mode_i  in  2  00 SIMPLEX, 01 HALFDUPLEX, 10 FULLDUPLEX, 11 reserved (treated as SIMPLEX)
master_i  in  1  SIMPLEX only: 1 transmit-only, 0 receive-only
flow_control_i  in  1  1 enables RTS/CTS handling
tx_pending_i  in  1  TX FIFO non-empty
tx_busy_i  in  1  TX engine shifting a frame (rises the cycle after tx_start_o, falls after stop bit)
rx_busy_i  in  1  RX engine mid-frame (start bit detected through stop bit)
rx_almost_full_i  in  1  RX FIFO at or above high watermark
cts_n_i  in  1  clear-to-send pin, asynchronous, active-low
tx_start_o  out  1  one-cycle grant: TX engine pops FIFO and starts one frame
rx_en_o  out  1  receiver may detect start bits
line_dir_o  out  1  1 = transmit driver enabled
rts_n_o  out  1  request-to-send pin, active-low
state_o  out  2  half-duplex FSM state: 00 IDLE, 01 TX, 10 TURN, 11 RX

Behaviour:
- One clock, clk. Reset rst is synchronous, active-high. All outputs are registered.
- Reset values:
  - tx_start_o=0, rx_en_o=0, line_dir_o=0, rts_n_o=1, state_o=00.
  - Counters = 0; CTS synchroniser flops = 1.
  - Active config = SIMPLEX, master=0.
  - Reset asserted mid-frame forces all of these values at the next edge.
- Active config: the mode/master/flow_control register.
  - Loads from the inputs on every cycle where tx_busy_i=0, rx_busy_i=0 and tx_start_o=0.
  - Otherwise holds. A config change therefore never splits a frame.
  - Loading a non-HALFDUPLEX mode forces the FSM to IDLE.
  - Loading HALFDUPLEX from another mode enters IDLE.
- cts_s: cts_n_i through a 2-flop synchroniser.
- may_tx = tx_pending_i & ~tx_busy_i & ~tx_start_o & (~flow_control | ~cts_s).
  - The ~tx_start_o term enforces at least one idle cycle between grants.
  - CTS deasserted mid-frame does not abort the frame; it blocks only the next start.
- tx_start_o(next) = may_tx & tx_allowed. tx_allowed per mode:
  - SIMPLEX master=1: tx_allowed=1, rx_en_o=0, line_dir_o=1.
  - SIMPLEX master=0: tx_allowed=0, rx_en_o=1, line_dir_o=0.
  - FULLDUPLEX: tx_allowed=1, rx_en_o=1, line_dir_o=1.
  - HALFDUPLEX: per FSM below.
- HALFDUPLEX FSM:
  - IDLE:
    - Outputs: rx_en_o=1, line_dir_o=0.
    - rx_busy_i=1 -> RX. RX wins when it coincides with may_tx.
    - Else may_tx -> TX.
  - TX:
    - Outputs: line_dir_o=1, rx_en_o=0, tx_allowed=1.
    - On the entry edge line_dir_o rises; the first tx_start_o occurs one cycle later.
    - Back-to-back frames are granted while may_tx holds.
    - Leave when tx_pending_i=0, tx_busy_i=0 and tx_start_o=0 -> TURN, counter cleared.
    - Flow-control stall: if tx_pending_i=1 but CTS blocks, stay in TX.
  - TURN:
    - Outputs: line_dir_o=0, rx_en_o=0.
    - Counter increments each cycle.
    - At TURNAROUND_CYCLES-1 -> IDLE, counter cleared.
  - RX:
    - Outputs: rx_en_o=1, line_dir_o=0, tx_allowed=0.
    - Counter clears while rx_busy_i=1, otherwise increments.
    - At RX_IDLE_CYCLES-1 -> IDLE.
  - tx_allowed=0 in IDLE, TURN and RX.
  - state_o = 00 outside HALFDUPLEX.
- rts_n_o:
  - flow_control=0: rts_n_o=0.
  - Else rts_n_o = rx_almost_full_i | ~rx_en(next), registered.
  - rts_n_o rises the cycle after the watermark is hit and whenever the receiver is disabled.
- Counters saturate; no wrap-around.

Test Plan:
1. FULLDUPLEX, flow_control=0, tx_pending high for 3 frames (tx_busy 10 cycles each) -> exactly 3 tx_start_o pulses, each 1 cycle, none while tx_busy_i=1; rx_en_o=1 and line_dir_o=1 throughout.
2. FULLDUPLEX, flow_control=1, cts_n_i=1 -> no tx_start_o. Drop cts_n_i -> first tx_start_o 3 cycles later. Raise cts_n_i mid-frame -> frame completes, no further start.
3. HALFDUPLEX, TURNAROUND_CYCLES=4, one frame -> state IDLE→TX (line_dir_o=1), tx_start_o next cycle. After tx_busy_i falls with FIFO empty -> TURN for exactly 4 cycles with line_dir_o=0, rx_en_o=0, then IDLE.
4. HALFDUPLEX IDLE, rx_busy_i and tx_pending_i rise same cycle -> RX, no tx_start_o. After rx_busy_i falls, RX_IDLE_CYCLES=8 -> IDLE, then TX.
5. flow_control=1, rx_almost_full_i pulse -> rts_n_o high exactly the following cycle. SIMPLEX master=0 -> tx_pending never granted.
6. Mode change FULLDUPLEX→SIMPLEX mid-frame -> config held until tx_busy_i falls. Assert rst mid-frame -> all outputs at reset values next edge, state_o=00.
